// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC types, defaults and target helpers
package pc_pkg;

  localparam int          AW_DEFAULT        = 32;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h0000_4180;
  localparam int          RAS_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_JMP,
    SEL_BR,
    SEL_JR,
    SEL_EXC,
    SEL_ERET
  } next_sel_e;

  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; a full push overwrites the oldest entry
module ras_stack #(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic [PW-1:0] top_idx;

  assign valid   = (count != '0);
  assign top_idx = wptr - PW'(1);
  assign top     = valid ? mem[top_idx] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointer wraps freely, so once full the next push lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + PW'(1);
      if (count != CW'(DEPTH)) begin
        count <= count + CW'(1);
      end
    end else if (pop && valid) begin
      wptr  <= wptr - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch PC register, next-PC priority select and jr $31 predictor
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int          AW        = AW_DEFAULT,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
  parameter int          RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          ifj,
  input  logic          ifjal,
  input  logic          ifjr,
  input  logic          jr_is_ra,
  input  logic          if_branch,
  input  logic [AW-1:0] pc_id,
  input  logic [31:0]   instr_id,
  input  logic [AW-1:0] jr_target,
  input  logic          exc_req,
  input  logic          eret,
  input  logic [AW-1:0] epc,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  output logic          pc_misalign,
  output logic [AW-1:0] ras_top,
  output logic          ras_valid
);

  next_sel_e     sel;
  logic [AW-1:0] next_pc;
  logic [31:0]   pc_id32;
  logic [AW-1:0] jmp_pc;
  logic [AW-1:0] br_pc;
  logic          pc_en;
  logic          ras_en;
  logic          unused_instr;

  assign unused_instr = ^instr_id[31:26];
  assign pc_plus4     = pc + AW'(4);
  assign pc_id32      = 32'(pc_id);
  assign jmp_pc       = AW'(jump_target(pc_id32[31:28], instr_id[25:0]));
  assign br_pc        = pc_id + AW'(branch_offset(instr_id[15:0]));

  always_comb begin
    sel = SEL_SEQ;
    if (exc_req)            sel = SEL_EXC;
    else if (eret)          sel = SEL_ERET;
    else if (ifj || ifjal)  sel = SEL_JMP;
    else if (if_branch)     sel = SEL_BR;
    else if (ifjr)          sel = SEL_JR;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_EXC:  next_pc = AW'(EXC_VEC);
      SEL_ERET: next_pc = epc;
      SEL_JMP:  next_pc = jmp_pc;
      SEL_BR:   next_pc = br_pc;
      SEL_JR:   next_pc = jr_target;
      default:  next_pc = pc_plus4;
    endcase
  end

  // An exception must always be taken, even over a stall; eret waits like any redirect.
  assign pc_en  = exc_req || !stall;
  assign ras_en = !stall && !exc_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= AW'(RESET_PC);
      pc_misalign <= 1'b0;
    end else if (pc_en) begin
      pc          <= next_pc;
      pc_misalign <= (next_pc[1:0] != 2'b00);
    end
  end

  ras_stack #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_en && ifjal),
    .pop       (ras_en && !ifjal && ifjr && jr_is_ra),
    .push_data (pc_id + AW'(8)),
    .top       (ras_top),
    .valid     (ras_valid)
  );

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - directed and random checks of pc_gen_unit against a queue-based model
module tb_pc_gen_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, stall, ifj, ifjal, ifjr, jr_is_ra, if_branch, exc_req, eret;
  logic [31:0] pc_id, instr_id, jr_target, epc;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        pc_misalign, ras_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .ifj         (ifj),
    .ifjal       (ifjal),
    .ifjr        (ifjr),
    .jr_is_ra    (jr_is_ra),
    .if_branch   (if_branch),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .jr_target   (jr_target),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_misalign (pc_misalign),
    .ras_top     (ras_top),
    .ras_valid   (ras_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    reset = 0; stall = 0; ifj = 0; ifjal = 0; ifjr = 0; jr_is_ra = 0;
    if_branch = 0; exc_req = 0; eret = 0;
    pc_id = 0; instr_id = 0; jr_target = 0; epc = 0;
  endtask

  task automatic model_update();
    logic [31:0] nxt, sx;
    if (reset) begin
      m_pc = RST_PC;
      m_mis = 1'b0;
      m_ras.delete();
    end else begin
      sx = {{16{instr_id[15]}}, instr_id[15:0]};
      if (exc_req)               nxt = EXC_PC;
      else if (eret)             nxt = epc;
      else if (ifj || ifjal)     nxt = {pc_id[31:28], instr_id[25:0], 2'b00};
      else if (if_branch)        nxt = pc_id + sx * 4;
      else if (ifjr)             nxt = jr_target;
      else                       nxt = m_pc + 4;
      if (exc_req || !stall) begin
        m_pc  = nxt;
        m_mis = (nxt % 4) != 0;
      end
      if (!stall && !exc_req) begin
        if (ifjal) begin
          m_ras.push_back(pc_id + 8);
          if (m_ras.size() > DEPTH) m_ras.delete(0);
        end else if (ifjr && jr_is_ra && m_ras.size() > 0) begin
          m_ras.delete(m_ras.size() - 1);
        end
      end
    end
  endtask

  task automatic step();
    logic [31:0] exp_top;
    @(posedge clk);
    model_update();
    #1;
    exp_top = (m_ras.size() > 0) ? m_ras[m_ras.size() - 1] : 32'h0;
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 4);
    check("misalign", {31'b0, pc_misalign}, {31'b0, m_mis});
    check("ras_valid", {31'b0, ras_valid}, {31'b0, m_ras.size() > 0});
    check("ras_top", ras_top, exp_top);
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    check("t1_reset_pc", pc, 32'h3000);
    reset = 0;
    step(); check("t1_seq1", pc, 32'h3004);
    step(); check("t1_seq2", pc, 32'h3008);
    step(); check("t1_seq3", pc, 32'h300C);

    pc_id = 32'h3010; instr_id = 32'h1000_FFFF; if_branch = 1;
    step(); check("t2_branch_back", pc, 32'h300C);
    idle(); ifj = 1; pc_id = 32'h3014; instr_id = 32'h0800_0C40;
    step(); check("t2_jump", pc, 32'h3100);

    idle(); stall = 1; ifj = 1; instr_id = 32'h0800_0000;
    step(); check("t3_stall1", pc, 32'h3100);
    step(); check("t3_stall2", pc, 32'h3100);
    exc_req = 1;
    step(); check("t3_exc_over_stall", pc, 32'h4180);
    idle(); eret = 1; epc = 32'h3020;
    step(); check("t3_eret", pc, 32'h3020);

    idle(); ifjal = 1; pc_id = 32'h3000; instr_id = 32'h0C00_0C00;
    step(); check("t4_jal_top", ras_top, 32'h3008); check("t4_jal_valid", {31'b0, ras_valid}, 32'd1);
    idle(); ifjr = 1; jr_is_ra = 1; jr_target = 32'h3008;
    step(); check("t4_jr_pc", pc, 32'h3008); check("t4_jr_valid", {31'b0, ras_valid}, 32'd0);

    for (int i = 0; i <= DEPTH; i++) begin
      idle(); ifjal = 1; pc_id = 32'h3000 + 32'(i) * 32'h10; instr_id = 32'h0C00_0C00;
      step();
    end
    check("t5_full_top", ras_top, 32'h3048);
    for (int i = 0; i < DEPTH; i++) begin
      idle(); ifjr = 1; jr_is_ra = 1; jr_target = 32'h3100;
      step();
    end
    check("t5_drained", {31'b0, ras_valid}, 32'd0);

    idle(); ifjr = 1; jr_target = 32'h3002;
    step(); check("t6_jr_pc", pc, 32'h3002); check("t6_misalign", {31'b0, pc_misalign}, 32'd1);
    idle(); ifjal = 1; pc_id = 32'h3000; instr_id = 32'h0C00_0C00;
    step();
    idle(); reset = 1;
    step();
    check("t6_reset_pc", pc, 32'h3000);
    check("t6_reset_mis", {31'b0, pc_misalign}, 32'd0);
    check("t6_reset_valid", {31'b0, ras_valid}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      idle();
      reset     = ($urandom % 64) == 0;
      stall     = ($urandom % 4) == 0;
      exc_req   = ($urandom % 16) == 0;
      eret      = ($urandom % 12) == 0;
      ifj       = ($urandom % 10) == 0;
      ifjal     = ($urandom % 5) == 0;
      ifjr      = ($urandom % 4) == 0;
      jr_is_ra  = ($urandom % 3) != 0;
      if_branch = ($urandom % 6) == 0;
      pc_id     = $urandom;
      instr_id  = $urandom;
      jr_target = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      epc       = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
